// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - two-requester (CPU/DMA) data-memory arbiter with a single-cycle memory access strobe
module dm_arb #(
   parameter int DEPTH_WORDS = 3073,
   parameter bit RR_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_req,
   input  logic        c_we,
   input  logic        c_bmode,
   input  logic [15:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_ack,
   output logic        c_err,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_bmode,
   input  logic [15:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic [13:0] m_addr,
   output logic [31:0] m_din,
   output logic        m_we,
   output logic        m_bmode,
   output logic [1:0]  m_bsel,
   input  logic [31:0] m_dout
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   state_t      state_nx;
   logic        grant;
   logic        capture;

   logic        sel_d;
   logic        req_we;
   logic        req_bm;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_err;

   logic        gnt_d;
   logic        last_d;
   logic        lat_we;
   logic        lat_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (c_req || d_req) state_nx = ACC;
         ACC:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant   = 1'b0;
      capture = 1'b0;
      case (state)
         IDLE:    grant   = c_req || d_req;
         ACC:     capture = 1'b1;
         default: ;
      endcase
   end

   // On a tie the round-robin pointer favours whoever was not served last.
   always_comb begin
      if (c_req && d_req) begin
         sel_d = RR_EN ? !last_d : 1'b0;
      end else begin
         sel_d = d_req;
      end
      req_we    = sel_d ? d_we    : c_we;
      req_bm    = sel_d ? d_bmode : c_bmode;
      req_addr  = sel_d ? d_addr  : c_addr;
      req_wdata = sel_d ? d_wdata : c_wdata;
      req_err   = (int'(req_addr[15:2]) >= DEPTH_WORDS) ||
                  (!req_bm && (req_addr[1:0] != 2'b00));
   end

   // Memory-side outputs are loaded at the grant so they hold outside ACC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_d   <= 1'b0;
         last_d  <= 1'b1;
         lat_we  <= 1'b0;
         lat_err <= 1'b0;
         m_addr  <= '0;
         m_din   <= '0;
         m_bmode <= 1'b0;
         m_bsel  <= '0;
         m_we    <= 1'b0;
      end else begin
         m_we <= 1'b0;
         if (grant) begin
            gnt_d   <= sel_d;
            last_d  <= sel_d;
            lat_we  <= req_we;
            lat_err <= req_err;
            m_addr  <= req_addr[15:2];
            m_din   <= req_wdata;
            m_bmode <= req_bm;
            m_bsel  <= req_addr[1:0];
            m_we    <= req_we && !req_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_ack   <= 1'b0;
         c_err   <= 1'b0;
         c_rdata <= '0;
         d_ack   <= 1'b0;
         d_err   <= 1'b0;
         d_rdata <= '0;
      end else begin
         c_ack <= 1'b0;
         c_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         if (capture) begin
            if (gnt_d) begin
               d_ack <= 1'b1;
               d_err <= lat_err;
               if (!lat_we && !lat_err) d_rdata <= m_dout;
            end else begin
               c_ack <= 1'b1;
               c_err <= lat_err;
               if (!lat_we && !lat_err) c_rdata <= m_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_dm_arb.sv
// tb/tb_dm_arb.sv - randomized bench for dm_arb against a transaction-level reference model
module tb_dm_arb;
   localparam int DW = 3073;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        c_req, c_we, c_bmode, d_req, d_we, d_bmode;
   logic [15:0] c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;
   logic        c_ack, c_err, d_ack, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic [13:0] m_addr;
   logic [31:0] m_din, m_dout;
   logic        m_we, m_bmode;
   logic [1:0]  m_bsel;

   logic        f_c_ack, f_c_err, f_d_ack, f_d_err, f_m_we, f_m_bmode;
   logic [31:0] f_c_rdata, f_d_rdata, f_m_din;
   logic [13:0] f_m_addr;
   logic [1:0]  f_m_bsel;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   dm_arb #(.DEPTH_WORDS(DW), .RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_bmode(c_bmode), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_bmode(d_bmode), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_bmode(m_bmode), .m_bsel(m_bsel),
      .m_dout(m_dout)
   );

   dm_arb #(.DEPTH_WORDS(DW), .RR_EN(1'b0)) dut_fixed (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_bmode(c_bmode), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(f_c_ack), .c_err(f_c_err), .c_rdata(f_c_rdata),
      .d_req(d_req), .d_we(d_we), .d_bmode(d_bmode), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(f_d_ack), .d_err(f_d_err), .d_rdata(f_d_rdata),
      .m_addr(f_m_addr), .m_din(f_m_din), .m_we(f_m_we), .m_bmode(f_m_bmode), .m_bsel(f_m_bsel),
      .m_dout(32'd0)
   );

   logic [31:0] mem    [16384];
   logic [31:0] shadow [16384];

   function automatic logic [31:0] rd_val(input logic [31:0] w, input logic bm, input logic [1:0] bs);
      logic [7:0] b;
      b = w[8*bs +: 8];
      return bm ? {{24{b[7]}}, b} : w;
   endfunction

   assign m_dout = rd_val(mem[m_addr], m_bmode, m_bsel);

   always @(posedge clk) begin
      if (m_we) begin
         if (m_bmode) mem[m_addr][8*m_bsel +: 8] <= m_din[7:0];
         else         mem[m_addr] <= m_din;
      end
   end

   task automatic chk(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: one transaction at a time, grant on an idle edge,
   // memory access on the next edge, acknowledge for the cycle after that.
   int          ph = 0;
   bit          last_d = 1'b1, gd = 1'b0;
   bit          t_we = 1'b0, t_bm = 1'b0, t_err = 1'b0;
   logic [15:0] t_addr = '0;
   logic [31:0] t_wd = '0;
   logic        e_c_ack = 0, e_d_ack = 0, e_c_err = 0, e_d_err = 0, e_m_we = 0, e_m_bm = 0;
   logic [31:0] e_c_rd = '0, e_d_rd = '0, e_m_din = '0;
   logic [13:0] e_m_addr = '0;
   logic [1:0]  e_m_bsel = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = 0; last_d = 1'b1;
         e_c_ack = 0; e_d_ack = 0; e_c_err = 0; e_d_err = 0; e_m_we = 0; e_m_bm = 0;
         e_c_rd = '0; e_d_rd = '0; e_m_din = '0; e_m_addr = '0; e_m_bsel = '0;
      end else begin
         case (ph)
            0: if (c_req || d_req) begin
               gd     = (c_req && d_req) ? !last_d : d_req;
               last_d = gd;
               t_we   = gd ? d_we : c_we;
               t_bm   = gd ? d_bmode : c_bmode;
               t_addr = gd ? d_addr : c_addr;
               t_wd   = gd ? d_wdata : c_wdata;
               t_err  = (int'(t_addr[15:2]) >= DW) || (!t_bm && t_addr[1:0] != 2'b00);
               e_m_addr = t_addr[15:2];
               e_m_din  = t_wd;
               e_m_bm   = t_bm;
               e_m_bsel = t_addr[1:0];
               e_m_we   = t_we && !t_err;
               ph = 1;
            end
            1: begin
               if (!t_err) begin
                  if (t_we) begin
                     if (t_bm) shadow[t_addr[15:2]][8*t_addr[1:0] +: 8] = t_wd[7:0];
                     else      shadow[t_addr[15:2]] = t_wd;
                  end else if (gd) begin
                     e_d_rd = rd_val(shadow[t_addr[15:2]], t_bm, t_addr[1:0]);
                  end else begin
                     e_c_rd = rd_val(shadow[t_addr[15:2]], t_bm, t_addr[1:0]);
                  end
               end
               e_m_we  = 0;
               e_c_ack = !gd; e_d_ack = gd;
               e_c_err = !gd && t_err; e_d_err = gd && t_err;
               ph = 2;
            end
            default: begin
               e_c_ack = 0; e_d_ack = 0; e_c_err = 0; e_d_err = 0;
               ph = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("c_ack",   c_ack == e_c_ack,   32'(c_ack),   32'(e_c_ack));
         chk("d_ack",   d_ack == e_d_ack,   32'(d_ack),   32'(e_d_ack));
         chk("c_err",   c_err == e_c_err,   32'(c_err),   32'(e_c_err));
         chk("d_err",   d_err == e_d_err,   32'(d_err),   32'(e_d_err));
         chk("c_rdata", c_rdata == e_c_rd,  c_rdata,      e_c_rd);
         chk("d_rdata", d_rdata == e_d_rd,  d_rdata,      e_d_rd);
         chk("m_we",    m_we == e_m_we,     32'(m_we),    32'(e_m_we));
         chk("m_addr",  m_addr == e_m_addr, 32'(m_addr),  32'(e_m_addr));
         chk("m_din",   m_din == e_m_din,   m_din,        e_m_din);
         chk("m_bmode", m_bmode == e_m_bm,  32'(m_bmode), 32'(e_m_bm));
         chk("m_bsel",  m_bsel == e_m_bsel, 32'(m_bsel),  32'(e_m_bsel));
      end
   end

   function automatic logic [15:0] rand_addr(input logic bm);
      int k;
      logic [15:0] a;
      k = $urandom_range(0, 7);
      if (k < 5) begin
         a = 16'($urandom_range(0, 255));
         if (!bm) a[1:0] = 2'b00;
      end else if (k == 5) begin
         a = 16'($urandom_range(0, 255)) | 16'h0001;
      end else if (k == 6) begin
         a = 16'h3000 + 16'($urandom_range(0, 31));
      end else begin
         a = 16'($urandom);
      end
      return a;
   endfunction

   task automatic new_c();
      c_we = 1'($urandom); c_bmode = 1'($urandom);
      c_addr = rand_addr(c_bmode); c_wdata = $urandom;
   endtask

   task automatic new_d();
      d_we = 1'($urandom); d_bmode = 1'($urandom);
      d_addr = rand_addr(d_bmode); d_wdata = $urandom;
   endtask

   task automatic do_acc(input logic who, input logic we, input logic bm, input logic [15:0] a,
                         input logic [31:0] wd, input logic [13:0] ema, input logic emwe,
                         input logic [1:0] ebs, input logic eerr, input logic [31:0] erd);
      if (who) begin
         d_req = 1; d_we = we; d_bmode = bm; d_addr = a; d_wdata = wd;
      end else begin
         c_req = 1; c_we = we; c_bmode = bm; c_addr = a; c_wdata = wd;
      end
      @(negedge clk);
      chk("acc_m_addr",  m_addr == ema,  32'(m_addr),  32'(ema));
      chk("acc_m_we",    m_we == emwe,   32'(m_we),    32'(emwe));
      chk("acc_m_bsel",  m_bsel == ebs,  32'(m_bsel),  32'(ebs));
      chk("acc_m_bmode", m_bmode == bm,  32'(m_bmode), 32'(bm));
      @(negedge clk);
      chk("lat_ack",   (who ? d_ack : c_ack) == 1'b1,   32'(who ? d_ack : c_ack), 32'd1);
      chk("lat_other", (who ? c_ack : d_ack) == 1'b0,   32'(who ? c_ack : d_ack), 32'd0);
      chk("lat_err",   (who ? d_err : c_err) == eerr,   32'(who ? d_err : c_err), 32'(eerr));
      chk("lat_rdata", (who ? d_rdata : c_rdata) == erd, who ? d_rdata : c_rdata, erd);
      c_req = 0; d_req = 0;
      @(negedge clk);
   endtask

   int  prev_t, nfc, nfd;
   bit  own, prev_own;

   initial begin
      logic [31:0] v;
      c_req = 0; c_we = 0; c_bmode = 0; c_addr = '0; c_wdata = '0;
      d_req = 0; d_we = 0; d_bmode = 0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 16384; i++) begin
         v = $urandom;
         mem[i] <= v;
         shadow[i] = v;
      end
      repeat (3) @(negedge clk);
      chk("rst_c_ack",   c_ack == 1'b0,   32'(c_ack),  32'd0);
      chk("rst_d_ack",   d_ack == 1'b0,   32'(d_ack),  32'd0);
      chk("rst_m_we",    m_we == 1'b0,    32'(m_we),   32'd0);
      chk("rst_m_addr",  m_addr == 14'd0, 32'(m_addr), 32'd0);
      chk("rst_m_din",   m_din == 32'd0,  m_din,       32'd0);
      chk("rst_c_rdata", c_rdata == 32'd0, c_rdata,    32'd0);
      chk("rst_d_rdata", d_rdata == 32'd0, d_rdata,    32'd0);
      rst_n = 1;
      @(negedge clk);

      do_acc(1'b0, 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 14'h004, 1'b1, 2'd0, 1'b0, 32'h0);
      do_acc(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,        14'h004, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF);
      do_acc(1'b0, 1'b0, 1'b0, 16'h0002, 32'h0,        14'h000, 1'b0, 2'd2, 1'b1, 32'hDEADBEEF);
      do_acc(1'b0, 1'b0, 1'b0, 16'h3004, 32'h0,        14'hC01, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF);
      do_acc(1'b1, 1'b1, 1'b1, 16'h0013, 32'h00000080, 14'h004, 1'b1, 2'd3, 1'b0, 32'h0);
      do_acc(1'b1, 1'b0, 1'b1, 16'h0013, 32'h0,        14'h004, 1'b0, 2'd3, 1'b0, 32'hFFFFFF80);

      c_we = 0; d_we = 0; c_bmode = 0; d_bmode = 0; c_addr = 16'h0010; d_addr = 16'h0014;
      c_req = 1; d_req = 1;
      prev_t = -1; nfc = 0; nfd = 0; prev_own = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (c_ack || d_ack) begin
            own = d_ack;
            if (prev_t >= 0) begin
               chk("rr_alternate", own != prev_own, 32'(own), 32'(!prev_own));
               chk("rr_gap", (t - prev_t) == 3, 32'(t - prev_t), 32'd3);
            end
            prev_t = t;
            prev_own = own;
         end
         if (f_d_ack) nfd++;
         if (f_c_ack) nfc++;
      end
      chk("fixed_no_d_grant", nfd == 0, 32'(nfd), 32'd0);
      chk("fixed_c_grants",   nfc >= 9, 32'(nfc), 32'd9);
      c_req = 0; d_req = 0;
      repeat (3) @(negedge clk);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (c_req && c_ack) begin
            if ($urandom_range(0, 1) == 0) c_req = 0; else new_c();
         end else if (!c_req && $urandom_range(0, 2) == 0) begin
            c_req = 1; new_c();
         end
         if (d_req && d_ack) begin
            if ($urandom_range(0, 1) == 0) d_req = 0; else new_d();
         end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; new_d();
         end
      end
      c_req = 0; d_req = 0;
      repeat (4) @(negedge clk);

      d_req = 1; d_we = 1; d_bmode = 0; d_addr = 16'h0020; d_wdata = 32'h12345678;
      @(negedge clk);
      chk("abort_acc_we", m_we == 1'b1, 32'(m_we), 32'd1);
      rst_n = 0; d_req = 0;
      #1;
      chk("abort_we_drop", m_we == 1'b0, 32'(m_we), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_dack", d_ack == 1'b0, 32'(d_ack), 32'd0);
      end
      chk("abort_no_write", mem[8] == shadow[8], mem[8], shadow[8]);
      #1 rst_n = 1;
      c_we = 0; d_we = 0; c_bmode = 0; d_bmode = 0; c_addr = 16'h0010; d_addr = 16'h0014;
      c_req = 1; d_req = 1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_c_first", c_ack == 1'b1, 32'(c_ack), 32'd1);
      chk("post_rst_no_d",    d_ack == 1'b0, 32'(d_ack), 32'd0);
      c_req = 0; d_req = 0;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3073, number of valid memory words (word index 0..DEPTH_WORDS-1).
REQ-002 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester C highest.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 c_req  input  1  requester C (CPU) request; held high until c_ack.
REQ-006 c_we, c_bmode  input  1 each  C write enable and byte-mode select.
REQ-007 c_addr  input  16  C byte address; c_wdata  input  32  C write data (byte in [7:0] when c_bmode).
REQ-008 c_ack  output  1  one-cycle completion pulse; c_err  output  1  valid with c_ack; c_rdata  output  32  valid with c_ack.
REQ-009 d_req, d_we, d_bmode, d_addr[15:0], d_wdata[31:0], d_ack, d_err, d_rdata[31:0]: requester D (DMA), same directions, widths and meaning as C.
REQ-010 m_addr  output  14  word address to data memory (byte address bits [15:2]).
REQ-011 m_din  output  32; m_we  output  1; m_bmode  output  1; m_bsel  output  2 (byte address bits [1:0]).
REQ-012 m_dout  input  32  memory read data; combinational on m_addr/m_bmode/m_bsel, byte reads already sign-extended.

Function
REQ-013 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE; every state lasts exactly one cycle except IDLE, which holds while no request is pending.
REQ-014 In IDLE, on an edge with c_req or d_req high, SHALL grant one requester, register its we/bmode/addr/wdata, and enter ACC.
REQ-015 Arbitration: if one request is pending, grant it; if both and RR_EN=1, grant the requester not granted last (pointer resets to D so C wins the first tie); if RR_EN=0, always grant C.
REQ-016 In ACC, m_addr/m_din/m_bmode/m_bsel SHALL reflect the latched request; m_we SHALL be high for this one cycle only if latched we=1 and no error.
REQ-017 At the end of ACC, SHALL capture m_dout into the granted requester's rdata (reads only; writes leave rdata unchanged) and enter DONE.
REQ-018 In DONE, the granted requester's ack SHALL be high for exactly one cycle; the other requester's ack SHALL stay low.
REQ-019 Latency: req high at edge T in IDLE -> ACC during cycle T+1 -> ack high during cycle T+2; throughput at most one access per 3 cycles.
REQ-020 Error: word index addr[15:2] >= DEPTH_WORDS, or bmode=0 with addr[1:0]!=0, SHALL raise err with ack, suppress m_we, and leave rdata unchanged.
REQ-021 The request inputs SHALL be ignored outside IDLE; a requester that keeps req high after ack SHALL be re-arbitrated on the next IDLE edge.
REQ-022 The round-robin pointer SHALL update only on a grant in IDLE.
REQ-023 m_we SHALL be low in IDLE and DONE; all m_* outputs SHALL hold their last value outside ACC except m_we.

Reset
REQ-024 While rst_n is low, SHALL force: state IDLE, all ack/err/m_we = 0, m_addr/m_din/m_bsel/m_bmode = 0, c_rdata/d_rdata = 0, RR pointer = D.
REQ-025 Reset asserted in ACC or DONE SHALL abort the access with no ack; an m_we not yet sampled by the memory SHALL be dropped asynchronously.
REQ-026 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-027 C word write addr 0x0010 data 0xDEADBEEF, then C word read 0x0010 -> m_we high for 1 cycle with m_addr=0x004; read c_ack at T+2 with c_rdata=0xDEADBEEF, c_err=0.
REQ-028 C and D requesting every cycle, RR_EN=1 -> grants alternate C,D,C,D; each ack exactly 3 cycles apart; with RR_EN=0 only C is granted while c_req is held.
REQ-029 D byte write 0x80 to 0x0013, then byte read 0x0013 -> m_bsel=3, m_bmode=1; d_rdata=0xFFFFFF80.
REQ-030 C word read 0x0002 (misaligned) and word read 0x3004 (index 3073) -> c_ack with c_err=1, m_we never high, c_rdata unchanged.
REQ-031 rst_n pulled low during ACC of a D write -> no d_ack, m_we low immediately; after release, a new C request is granted first.
